// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   state_t      - controller state encoding (IDLE/RUN/DONE, 2'd3 unused)
//   cnt_width()  - ceiling log2, used to size the bit counter
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2,
        UNUSED = 2'd3
    } state_t;

    // Ceiling log2 of n, never less than 1 so a counter always has a bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/full_adder.sv
// ha / full_adder
// Single-bit adder cell built from two half adders.
// ha ports:         a, b (in) -> sum, carry (out)
// full_adder ports: a, b, c (in) -> sum1, carry1 (out)
module ha (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum1,
    output logic carry1
);
    logic s_ab;
    logic c_ab;
    logic c_sc;

    ha u_ha0 (.a(a),    .b(b), .sum(s_ab), .carry(c_ab));
    ha u_ha1 (.a(s_ab), .b(c), .sum(sum1), .carry(c_sc));

    assign carry1 = c_ab | c_sc;
endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial ripple adder: one full_adder cell processes one operand bit per
// clock, LSB first, with the carry held in a flip-flop between bits.
// {cout,sum} = a + b + cin after WIDTH cycles in RUN.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - add request (accepted in IDLE or DONE)
//   a, b  - WIDTH-bit operands, cin - carry-in (captured on accept)
//   busy  - high while RUN
//   done  - one-cycle pulse when sum/cout hold a new result
//   sum   - registered result, cout - registered carry-out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH + 1);

    state_t           state_reg;
    state_t           state_next;
    logic             load;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH-1:0] a_sh_next;
    logic [WIDTH-1:0] b_sh_next;
    logic [WIDTH-1:0] sum_sh_next;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    full_adder u_fa (
        .a      (a_sh_reg[0]),
        .b      (b_sh_reg[0]),
        .c      (carry_reg),
        .sum1   (fa_sum),
        .carry1 (fa_carry)
    );

    // Right-shift networks. The new sum bit enters at the MSB so that after
    // WIDTH shifts the LSB-first stream sits in natural bit order.
    assign a_sh_next[WIDTH-1]   = 1'b0;
    assign b_sh_next[WIDTH-1]   = 1'b0;
    assign sum_sh_next[WIDTH-1] = fa_sum;
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_sh_next[gi]   = a_sh_reg[gi + 1];
            assign b_sh_next[gi]   = b_sh_reg[gi + 1];
            assign sum_sh_next[gi] = sum_sh_reg[gi + 1];
        end
    endgenerate

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = IDLE;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                state_next = last_bit ? DONE : RUN;
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                a_sh_reg   <= a;
                b_sh_reg   <= b;
                carry_reg  <= cin;
                sum_sh_reg <= '0;
                cnt_reg    <= '0;
            end else if (state_reg == RUN) begin
                a_sh_reg   <= a_sh_next;
                b_sh_reg   <= b_sh_next;
                sum_sh_reg <= sum_sh_next;
                carry_reg  <= fa_carry;
                cnt_reg    <= cnt_reg + 1'b1;
                // Publish straight from the shift network so the final bit
                // is included and sum never exposes a partial value.
                if (last_bit) begin
                    sum_reg  <= sum_sh_next;
                    cout_reg <= fa_carry;
                end
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
